data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
Multi-cycle data memory with load/store controller, sitting directly upstream of the CPU's memory data register. It accepts one byte, halfword or word request at a time and inserts a configurable number of wait states. Loads are aligned and sign- or zero-extended before being presented on rdata, so the data register captures an architecture-ready value. Misaligned accesses are flagged and never touch memory.

Parameters:
ADDR_W, 8, word-address width; memory holds 2**ADDR_W 32-bit words
WAIT_CYCLES, 2, wait states between accept and completion (0 allowed)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
req  input  1  request strobe; sampled only in IDLE
we  input  1  1 = store, 0 = load
size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word
sign_ext  input  1  loads only: 1 sign-extend, 0 zero-extend
addr  input  32  byte address
wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0])
rdata  output  32  aligned, extended load result
ready  output  1  one-cycle completion pulse
misalign  output  1  valid with ready; 1 = access rejected
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; rdata=0; ready=0; misalign=0; busy=0; wait counter=0; latched request cleared. Memory array is not cleared; simulation initialises it to 0.
- Deassertion of reset takes effect on the next rising edge. Reset mid-request abandons the request with no memory write.
- FSM states: IDLE, WAIT, ACCESS, ERR.
- IDLE, req=1: latch we, size, sign_ext, addr and wdata.
  - Misaligned request (half with addr[0]=1, or word with addr[1:0]!=0): go to ERR.
  - Else, WAIT_CYCLES>0: go to WAIT with counter=WAIT_CYCLES-1.
  - Else: go to ACCESS.
- IDLE, req=0: stay in IDLE.
- WAIT: if counter==0, go to ACCESS; else decrement the counter. Inputs are ignored.
- ACCESS, one cycle, then return to IDLE:
  - Assert ready=1 and misalign=0 as registered outputs in the cycle after ACCESS, i.e. with IDLE.
  - Store: write only the addressed byte lanes of word addr[ADDR_W+1:2]. Byte order is little-endian: lane k = bits [8k+7:8k], selected by addr[1:0]. rdata is unchanged.
  - Load: read the word, shift the selected lane(s) to bit 0 and extend per sign_ext. Word loads ignore sign_ext. rdata updates together with ready.
- ERR: one cycle, then IDLE. ready=1 and misalign=1 for one cycle. No write; rdata holds its previous value.
- Total latency from the accept edge to the ready pulse is WAIT_CYCLES+2 cycles for a good access and 2 cycles for a misaligned one.
- rdata holds its value until the next completed load.
- req held high continuously: a new request is accepted in the cycle ready is high, because the FSM is back in IDLE. Back-to-back throughput is one request per WAIT_CYCLES+2 cycles.
- Address bits above ADDR_W+1 are ignored, so addresses wrap modulo the memory size. No error is raised for out-of-range addresses.
- A store followed by a load to the same word returns the new data, since the write completes in ACCESS.
- size=11 behaves exactly as a word access.

Test Plan:
- Reset: hold rst_n=0 while req=1 -> rdata=0, ready=0, busy=0; no write occurs (a later load of addr 0 returns 0).
- Word round trip, WAIT_CYCLES=2: store 0xDEADBEEF at 0x10, then load word 0x10 -> ready pulses exactly 4 cycles after each accept; rdata=0xDEADBEEF.
- Byte/half extension, word 0x10=0xDEADBEEF:
  - lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE
  - lh 0x10 -> 0xFFFFBEEF; lhu 0x12 -> 0x0000DEAD
- Partial store: sb 0x55 to 0x11 over 0xDEADBEEF, then lw 0x10 -> 0xDEAD55EF. sh 0x1234 to 0x12, then lw 0x10 -> 0x123455EF.
- Misalign: lw at 0x12 and sh at 0x11 -> ready and misalign both high 2 cycles after accept; rdata unchanged; memory unchanged.
- Wrap and reset mid-op with ADDR_W=8: store 0xCAFEF00D at 0x410, then lw 0x010 -> 0xCAFEF00D. Start a store, pulse rst_n low during WAIT -> ready never pulses and the target word keeps its old value.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data memory with a byte/half/word load/store controller.
// Loads are lane-aligned and extended; misaligned requests are rejected without touching memory.
module data_mem_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        misalign,
    output logic        busy
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_ERR    = 2'd3;

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              sext_q, sext_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              mis_q, mis_d;

    logic [31:0] mem [2**ADDR_W];

    // High address bits are deliberately dropped so accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    logic              req_mis;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane;
    logic [3:0]        be;
    logic [31:0]       wd_rep;
    logic [31:0]       rword;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_val;

    assign req_mis  = (size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
    assign word_idx = addr_q[ADDR_W+1:2];
    assign lane     = addr_q[1:0];
    assign rword    = mem[word_idx];
    assign byte_sel = rword[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        be       = 4'b1111;
        wd_rep   = wdata_q;
        load_val = rword;
        case (size_q)
            2'b00: begin
                be       = 4'b0001 << lane;
                wd_rep   = {4{wdata_q[7:0]}};
                load_val = {{24{sext_q & byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                be       = lane[1] ? 4'b1100 : 4'b0011;
                wd_rep   = {2{wdata_q[15:0]}};
                load_val = {{16{sext_q & half_sel[15]}}, half_sel};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        sext_d  = sext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        mis_d   = 1'b0;
        case (state_q)
            S_IDLE: if (req) begin
                we_d    = we;
                size_d  = size;
                sext_d  = sign_ext;
                addr_d  = addr[ADDR_W+1:0];
                wdata_d = wdata;
                if (req_mis)              state_d = S_ERR;
                else if (WAIT_CYCLES > 0) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_INIT;
                end
                else                      state_d = S_ACCESS;
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_ACCESS;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_ACCESS: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                if (!we_q) rdata_d = load_val;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                mis_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            mis_q   <= mis_d;
        end
    end

    // Array is not reset; a reset forces IDLE, so an abandoned store never reaches here.
    always_ff @(posedge clk) begin
        if (state_q == S_ACCESS && we_q) begin
            for (int k = 0; k < 4; k++)
                if (be[k]) mem[word_idx][8*k +: 8] <= wd_rep[8*k +: 8];
        end
    end

    assign rdata    = rdata_q;
    assign ready    = ready_q;
    assign misalign = mis_q;
    assign busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench: each request pushes its expected completion, checked when ready pulses.
module tb_data_mem_ctrl;
    localparam int ADDR_W = 8;
    localparam int WAIT_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0, we = 1'b0, sign_ext = 1'b0;
    logic [1:0]  size = 2'b10;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        ready, misalign, busy;

    data_mem_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .misalign(misalign), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        mis;
        logic [31:0] rd;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0, n_pass = 0;
    int          cyc = 0;
    logic [31:0] last_rd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && ready) begin
            if (sb.size() == 0) chk("spurious_ready", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.tag, "_mis"}, {31'd0, misalign}, {31'd0, e.mis});
                chk({e.tag, "_rdata"}, rdata, e.rd);
                chk({e.tag, "_lat"}, cyc - e.acc + 1, e.lat);
            end
        end
    end

    task automatic op(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                      input logic [31:0] a, input logic [31:0] wd, input logic mis,
                      input logic [31:0] exp_rd);
        exp_t e;
        @(negedge clk);
        we = w; size = sz; sign_ext = sx; addr = a; wdata = wd; req = 1'b1;
        if (!w && !mis) last_rd = exp_rd;
        e.tag = tag; e.mis = mis; e.rd = last_rd;
        e.lat = mis ? 2 : WAIT_CYCLES + 2;
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        req = 1'b0;
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mis", {31'd0, misalign}, 32'd0);
        rst_n = 1'b1;

        // Reset held with a store pending must not write.
        op("sw0", 1'b1, 2'b10, 1'b0, 32'h0, 32'h01020304, 1'b0, 32'h0);
        @(negedge clk);
        rst_n = 1'b0; req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h0; wdata = 32'hFFFFFFFF;
        repeat (3) @(negedge clk);
        chk("rst2_busy", {31'd0, busy}, 32'd0);
        chk("rst2_ready", {31'd0, ready}, 32'd0);
        req = 1'b0; rst_n = 1'b1; last_rd = '0;
        op("lw0", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 32'h01020304);

        op("sw10",  1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        op("lw10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
        op("lb13",  1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, 32'hFFFFFFDE);
        op("lbu13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 32'h000000DE);
        op("lh10",  1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0, 32'hFFFFBEEF);
        op("lhu12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 32'h0000DEAD);
        op("lw_sx", 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
        op("sb11",  1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF55, 1'b0, 32'h0);
        op("lw_sb", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD55EF);
        op("sh12",  1'b1, 2'b01, 1'b0, 32'h12, 32'hABCD1234, 1'b0, 32'h0);
        op("lw_sh", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h123455EF);

        op("mis_lw12", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b1, 32'h0);
        op("mis_sh11", 1'b1, 2'b01, 1'b0, 32'h11, 32'h00009999, 1'b1, 32'h0);
        op("mis_sw11", 1'b1, 2'b11, 1'b0, 32'h11, 32'h77777777, 1'b1, 32'h0);
        op("lw_after_mis", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h123455EF);
        op("lsz11", 1'b0, 2'b11, 1'b1, 32'h10, 32'h0, 1'b0, 32'h123455EF);
        op("lb_lane0", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 1'b0, 32'hFFFFFFEF);
        op("lhu_lane0", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b0, 32'h000055EF);

        op("sw410", 1'b1, 2'b10, 1'b0, 32'h410, 32'hCAFEF00D, 1'b0, 32'h0);
        op("lw_wrap", 1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 1'b0, 32'hCAFEF00D);

        // Reset pulse during WAIT abandons the store.
        op("sw20", 1'b1, 2'b10, 1'b0, 32'h20, 32'hAAAA5555, 1'b0, 32'h0);
        @(negedge clk);
        we = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'h12345678; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_rdata", rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; last_rd = '0;
        repeat (8) @(negedge clk);
        op("lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'hAAAA5555);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
